// File: rtl/hifi4_iram0_loader.sv
// hifi4_iram0_loader
// Turns a 32-bit word request stream into 128-bit IRAM0 line accesses.
// Writes to one line are merged in a combining buffer and issued as a single
// masked write. Reads wait for the buffer to drain, issue a full-line read and
// return the addressed word after the fixed memory latency.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   IDLE     | buffer empty, any request may be accepted
//   MERGE    | buffer holds a partial line, same-line writes merge in
//   FLUSH    | masked line write presented to IRAM0 until taken
//   RD_ISSUE | full-line read presented to IRAM0 until taken
//   RD_WAIT  | counting down the read latency, then returning the word
module hifi4_iram0_loader #(
  parameter logic [31:0] BASE   = 32'h4000_0000,
  parameter logic [31:0] LIMIT  = 32'h4000_FFFF,
  parameter int          AWIDTH = 12,
  parameter int          RD_LAT = 2
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWr,
  input  logic [31:0]       ReqAddr,
  input  logic [31:0]       ReqWrData,
  input  logic              Flush,
  output logic              RspValid,
  output logic [31:0]       RspData,
  output logic              RspErr,
  output logic [AWIDTH-1:0] IRam0Addr,
  output logic              IRam0En,
  output logic              IRam0Wr,
  output logic [3:0]        IRam0WordEn,
  output logic [127:0]      IRam0WrData,
  output logic              IRam0LoadStore,
  input  logic              IRam0Busy,
  input  logic [127:0]      IRam0Data
);

  typedef enum logic [2:0] {IDLE, MERGE, FLUSH, RD_ISSUE, RD_WAIT} state_t;

  localparam int CW = (RD_LAT < 1) ? 1 : $clog2(RD_LAT + 1);

  state_t            state, state_nxt;
  logic              rdy_en;
  logic [AWIDTH-1:0] buf_tag;
  logic [3:0][31:0]  buf_data;
  logic [3:0]        buf_mask;
  logic [1:0]        rd_word;
  logic [CW-1:0]     lat_cnt;

  logic [AWIDTH-1:0] req_line;
  logic [1:0]        req_word;
  logic [3:0]        req_onehot;
  logic              req_err;
  logic              req_acc;
  logic              acc_ok;
  logic              taken;
  logic              buf_full;
  logic              tag_hit;
  logic              rd_done;

  // BASE is line aligned, so the line index is a plain subtraction of bits [AWIDTH+3:4]
  assign req_line   = ReqAddr[AWIDTH+3:4] - BASE[AWIDTH+3:4];
  assign req_word   = ReqAddr[3:2];
  assign req_onehot = 4'b0001 << req_word;
  assign req_err    = (ReqAddr[1:0] != 2'b00) || (ReqAddr < BASE) || (ReqAddr > LIMIT);
  assign req_acc    = ReqValid & ReqReady;
  assign acc_ok     = req_acc & ~req_err;
  assign taken      = IRam0En & ~IRam0Busy;
  assign buf_full   = &buf_mask;
  assign tag_hit    = (req_line == buf_tag);
  assign rd_done    = (state == RD_WAIT) && (lat_cnt == CW'(1));

  assign IRam0LoadStore = 1'b1;

  // State register
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:     if (acc_ok) state_nxt = ReqWr ? MERGE : RD_ISSUE;
      MERGE:    if (buf_full || Flush || (ReqValid && !ReqReady)) state_nxt = FLUSH;
      FLUSH:    if (taken) state_nxt = IDLE;
      RD_ISSUE: if (taken) state_nxt = RD_WAIT;
      RD_WAIT:  if (lat_cnt == CW'(1)) state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
  end

  // Request handshake: in MERGE only same-line writes are taken, and not once a drain is due
  always_comb begin
    ReqReady = 1'b0;
    case (state)
      IDLE:    ReqReady = rdy_en;
      MERGE:   ReqReady = rdy_en & ~buf_full & ~Flush & ReqWr & tag_hit;
      default: ReqReady = 1'b0;
    endcase
  end

  // Holds ReqReady low until the first edge after reset is released
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) rdy_en <= 1'b0;
    else       rdy_en <= 1'b1;
  end

  // Combining buffer: load on the first write, merge same-line writes, empty when the flush is taken
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      buf_tag  <= '0;
      buf_data <= '0;
      buf_mask <= '0;
    end else if (state == IDLE && acc_ok && ReqWr) begin
      buf_tag            <= req_line;
      buf_data           <= '0;
      buf_data[req_word] <= ReqWrData;
      buf_mask           <= req_onehot;
    end else if (state == MERGE && acc_ok) begin
      buf_data[req_word] <= ReqWrData;
      buf_mask           <= buf_mask | req_onehot;
    end else if (state == FLUSH && taken) begin
      buf_mask <= '0;
    end
  end

  // Read context: word select remembered at acceptance, latency counted from the taking edge
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      rd_word <= '0;
      lat_cnt <= '0;
    end else begin
      if (state == IDLE && acc_ok && !ReqWr) rd_word <= req_word;
      if (state == RD_ISSUE && taken)        lat_cnt <= CW'(RD_LAT);
      else if (state == RD_WAIT)             lat_cnt <= lat_cnt - CW'(1);
    end
  end

  // Memory-side outputs: loaded when an access starts, held through Busy, strobe dropped when taken
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      IRam0En     <= 1'b0;
      IRam0Wr     <= 1'b0;
      IRam0WordEn <= '0;
      IRam0Addr   <= '0;
      IRam0WrData <= '0;
    end else if (state == MERGE && state_nxt == FLUSH) begin
      IRam0En     <= 1'b1;
      IRam0Wr     <= 1'b1;
      IRam0WordEn <= buf_mask;
      IRam0Addr   <= buf_tag;
      IRam0WrData <= buf_data;
    end else if (state == IDLE && state_nxt == RD_ISSUE) begin
      IRam0En     <= 1'b1;
      IRam0Wr     <= 1'b0;
      IRam0WordEn <= 4'hF;
      IRam0Addr   <= req_line;
    end else if (taken) begin
      IRam0En <= 1'b0;
      IRam0Wr <= 1'b0;
    end
  end

  // Response: single-cycle pulse for an erroring request or a completed read
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      RspValid <= 1'b0;
      RspErr   <= 1'b0;
      RspData  <= '0;
    end else begin
      RspValid <= 1'b0;
      RspErr   <= 1'b0;
      if (req_acc && req_err) begin
        RspValid <= 1'b1;
        RspErr   <= 1'b1;
        RspData  <= '0;
      end else if (rd_done) begin
        RspValid <= 1'b1;
        RspData  <= IRam0Data[{rd_word, 5'b00000} +: 32];
      end
    end
  end

endmodule
